west_feeder_ctrl: RTL and testbench

- Write-side controller for the west-edge row FIFO bank of the systolic array.
- Accepts a single valid/ready byte stream of activation vectors and de-interleaves it into per-row FIFO writes. Element j of each vector goes to row j.
- Once a full tile is loaded, it issues diagonally skewed per-row read enables so row i starts streaming i cycles after row 0.
- Sits between the activation DMA/stream source and the west FIFO bank.

---
 rtl/west_feeder_ctrl.sv | 142 ++++++++++++++
 tb/tb_west_feeder_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/west_feeder_ctrl.sv
// Write-side controller for the west-edge row FIFO bank: de-interleaves an
// activation byte stream into per-row FIFO writes, then issues skewed row reads.
module west_feeder_ctrl #(
    parameter int ROW    = 9,
    parameter int W_DATA = 8,
    parameter int W_CNT  = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [W_CNT-1:0]  i_tile_len,
    input  logic [W_DATA-1:0] i_s_data,
    input  logic              i_s_valid,
    output logic              o_s_ready,
    output logic [W_DATA-1:0] o_data,
    output logic [ROW-1:0]    o_write_enable,
    input  logic [ROW-1:0]    i_fifo_full,
    output logic [ROW-1:0]    o_read_enable,
    output logic              o_busy,
    output logic              o_done
);

    localparam int RW = (ROW > 1) ? $clog2(ROW) : 1;
    localparam int TW = W_CNT + $clog2(ROW) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FEED = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t           state_r;
    logic [W_CNT-1:0] len_r;
    logic [W_CNT-1:0] vec_cnt_r;
    logic [RW-1:0]    row_ptr_r;
    logic [TW-1:0]    t_r;
    logic             hs_s;
    logic             last_beat_s;
    logic             feed_end_s;

    // Row i is enabled during the len-cycle window starting at FEED cycle i.
    function automatic logic [ROW-1:0] feed_pattern(input logic [TW-1:0] t,
                                                    input logic [W_CNT-1:0] len);
        logic [ROW-1:0] p;
        p = '0;
        for (int i = 0; i < ROW; i++) begin
            p[i] = (t >= TW'(i)) && (t < (TW'(i) + TW'(len)));
        end
        return p;
    endfunction

    // Stream ready and beat/phase decode from the current registers.
    always_comb begin
        o_s_ready   = 1'b0;
        hs_s        = 1'b0;
        last_beat_s = 1'b0;
        feed_end_s  = 1'b0;
        if (state_r == ST_LOAD) begin
            o_s_ready = !i_fifo_full[row_ptr_r];
        end else begin
            o_s_ready = 1'b0;
        end
        hs_s        = o_s_ready && i_s_valid;
        last_beat_s = (row_ptr_r == RW'(ROW - 1)) && (vec_cnt_r == (len_r - W_CNT'(1)));
        feed_end_s  = (t_r == (TW'(len_r) + TW'(ROW - 2)));
    end

    // Tile sequencer with registered write, read, busy and done outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r        <= ST_IDLE;
            len_r          <= '0;
            vec_cnt_r      <= '0;
            row_ptr_r      <= '0;
            t_r            <= '0;
            o_data         <= '0;
            o_write_enable <= '0;
            o_read_enable  <= '0;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
        end else begin
            o_write_enable <= '0;
            o_done         <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (i_start && (i_tile_len != '0)) begin
                        len_r     <= i_tile_len;
                        row_ptr_r <= '0;
                        vec_cnt_r <= '0;
                        o_busy    <= 1'b1;
                        state_r   <= ST_LOAD;
                    end else begin
                        o_busy <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (hs_s) begin
                        o_data         <= i_s_data;
                        o_write_enable <= ROW'(1'b1) << row_ptr_r;
                        if (row_ptr_r == RW'(ROW - 1)) begin
                            row_ptr_r <= '0;
                            vec_cnt_r <= vec_cnt_r + W_CNT'(1);
                        end else begin
                            row_ptr_r <= row_ptr_r + RW'(1);
                        end
                        // Last write lands in the first FEED cycle, alongside row 0's first read.
                        if (last_beat_s) begin
                            t_r           <= '0;
                            o_read_enable <= feed_pattern('0, len_r);
                            state_r       <= ST_FEED;
                        end else begin
                            state_r <= ST_LOAD;
                        end
                    end else begin
                        state_r <= ST_LOAD;
                    end
                end
                ST_FEED: begin
                    if (feed_end_s) begin
                        o_read_enable <= '0;
                        o_done        <= 1'b1;
                        state_r       <= ST_DONE;
                    end else begin
                        t_r           <= t_r + TW'(1);
                        o_read_enable <= feed_pattern(t_r + TW'(1), len_r);
                    end
                end
                ST_DONE: begin
                    o_busy  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    o_busy        <= 1'b0;
                    o_read_enable <= '0;
                    state_r       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_west_feeder_ctrl.sv
// Randomized self-checking bench for west_feeder_ctrl: a beat-count model predicts
// row/data of every write and the skewed read window of every FEED cycle.
module tb_west_feeder_ctrl;

    localparam int ROW    = 3;
    localparam int W_DATA = 8;
    localparam int W_CNT  = 8;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [W_CNT-1:0]  tile_len;
    logic [W_DATA-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic [W_DATA-1:0] wdata;
    logic [ROW-1:0]    we;
    logic [ROW-1:0]    full;
    logic [ROW-1:0]    re;
    logic              busy;
    logic              done;

    int n_checks = 0;
    int n_errors = 0;

    west_feeder_ctrl #(.ROW(ROW), .W_DATA(W_DATA), .W_CNT(W_CNT)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_start        (start),
        .i_tile_len     (tile_len),
        .i_s_data       (s_data),
        .i_s_valid      (s_valid),
        .o_s_ready      (s_ready),
        .o_data         (wdata),
        .o_write_enable (we),
        .i_fifo_full    (full),
        .o_read_enable  (re),
        .o_busy         (busy),
        .o_done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_we"}, 32'(we), 32'd0);
        chk({tag, "_re"}, 32'(re), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
    endtask

    // Runs one tile from start to the IDLE cycle after done; called at a negedge.
    task automatic run_tile(input int len, input int gap_pct, input int full_pct,
                            input bit seq_data, input int stall_row1, input bit start_in_feed);
        int total;
        int beats;
        int cyc;
        int stall_left;
        bit exp_v;
        int exp_row;
        logic [W_DATA-1:0] exp_d;
        logic [ROW-1:0] exp_we;
        logic [ROW-1:0] exp_re;
        logic [ROW-1:0] f;
        bit m_ready;
        total      = len * ROW;
        beats      = 0;
        cyc        = 0;
        stall_left = stall_row1;
        exp_v      = 1'b0;
        exp_row    = 0;
        exp_d      = '0;
        start      = 1'b1;
        tile_len   = W_CNT'(len);
        s_valid    = 1'b0;
        full       = '0;
        @(negedge clk);
        start = 1'b0;
        chk("load_busy", 32'(busy), 32'd1);
        while (beats < total && cyc < 20000) begin
            exp_we = '0;
            if (exp_v) exp_we[exp_row] = 1'b1;
            chk("load_we", 32'(we), 32'(exp_we));
            if (exp_v) chk("load_data", 32'(wdata), 32'(exp_d));
            chk("load_re", 32'(re), 32'd0);
            chk("load_done", 32'(done), 32'd0);
            s_valid = (int'($urandom_range(99)) >= gap_pct);
            s_data  = seq_data ? W_DATA'(8'h10 + beats) : W_DATA'($urandom);
            for (int i = 0; i < ROW; i++) f[i] = (int'($urandom_range(99)) < full_pct);
            if (stall_left > 0 && (beats % ROW) == 1) begin
                f = '0;
                f[1] = 1'b1;
                stall_left--;
            end
            full = f;
            #1;
            m_ready = !f[beats % ROW];
            chk("load_ready", 32'(s_ready), 32'(m_ready));
            exp_v   = s_valid && m_ready;
            exp_row = beats % ROW;
            exp_d   = s_data;
            if (exp_v) beats++;
            @(negedge clk);
            cyc++;
        end
        if (beats < total) begin
            chk("load_timeout", 32'(beats), 32'(total));
            return;
        end
        for (int t = 0; t < len + ROW - 1; t++) begin
            exp_we = '0;
            if (t == 0) exp_we[exp_row] = 1'b1;
            chk("feed_we", 32'(we), 32'(exp_we));
            if (t == 0) chk("feed_last_data", 32'(wdata), 32'(exp_d));
            exp_re = '0;
            for (int r = 0; r < ROW; r++) exp_re[r] = (t - r >= 0) && (t - r < len);
            chk("feed_re", 32'(re), 32'(exp_re));
            chk("feed_busy", 32'(busy), 32'd1);
            chk("feed_done", 32'(done), 32'd0);
            start    = start_in_feed && (t == 1);
            tile_len = W_CNT'(5);
            s_valid  = $urandom_range(1);
            full     = '0;
            #1;
            chk("feed_ready", 32'(s_ready), 32'd0);
            @(negedge clk);
        end
        start   = 1'b0;
        s_valid = 1'b0;
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_busy", 32'(busy), 32'd1);
        chk("done_re", 32'(re), 32'd0);
        @(negedge clk);
        chk_idle_outputs("post_done");
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        tile_len = '0;
        s_data   = '0;
        s_valid  = 1'b0;
        full     = '0;
        #2;
        chk_idle_outputs("reset");
        chk("reset_ready", 32'(s_ready), 32'd0);
        chk("reset_data", 32'(wdata), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic tile, then backpressure on row 1, then valid gaps.
        run_tile(2, 0, 0, 1'b1, 0, 1'b0);
        run_tile(2, 0, 0, 1'b1, 5, 1'b0);
        run_tile(2, 50, 0, 1'b1, 0, 1'b0);

        // Zero-length start is ignored.
        start    = 1'b1;
        tile_len = '0;
        s_valid  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk_idle_outputs("len0");
            #1;
            chk("len0_ready", 32'(s_ready), 32'd0);
            @(negedge clk);
        end
        s_valid = 1'b0;

        // Start during FEED has no effect.
        run_tile(3, 20, 10, 1'b0, 0, 1'b1);

        // Reset in the middle of LOAD after 4 beats.
        start    = 1'b1;
        tile_len = W_CNT'(2);
        @(negedge clk);
        start   = 1'b0;
        s_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            s_data = W_DATA'(8'h20 + k);
            @(negedge clk);
        end
        chk("pre_reset_busy", 32'(busy), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("mid_reset");
        chk("mid_reset_ready", 32'(s_ready), 32'd0);
        chk("mid_reset_data", 32'(wdata), 32'd0);
        s_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_tile(1, 0, 0, 1'b1, 0, 1'b0);

        // Randomized tiles.
        for (int n = 0; n < 6; n++) begin
            run_tile(int'($urandom_range(8, 1)), 30, 20, 1'b0, 0, 1'b0);
        end

        // Maximum tile length.
        run_tile(255, 0, 0, 1'b0, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
